serial_frame_rx_ctrl: RTL and testbench

Frame-level receive controller sitting directly above `serial_async_rx`. It enables the receiver and edge-detects its word-finished strobe. It parses a framed byte stream of the form SYNC, LEN, payload, CHK into an internal buffer. Only checksum-verified payloads are released to the downstream consumer, as a valid/ready byte stream with a last marker. Framing, length, checksum, inter-byte timeout and overrun failures are dropped and counted.

---
 rtl/serial_frame_rx_ctrl_pkg.sv | 15 +
 rtl/serial_frame_rx_ctrl_if.sv | 10 +
 rtl/serial_frame_rx_ctrl_frame_buf.sv | 32 +++
 rtl/serial_frame_rx_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_serial_frame_rx_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_frame_rx_ctrl_pkg.sv
// rtl/serial_frame_rx_ctrl_pkg.sv - shared types and constants for the frame receive controller
package serial_frame_pkg;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_LENGTH,
        ST_PAYLOAD,
        ST_CHECK,
        ST_DRAIN
    } t_frame_state;

endpackage

// File: rtl/serial_frame_rx_ctrl_if.sv
// rtl/serial_frame_rx_ctrl_if.sv - payload byte stream between the frame controller and its consumer
interface serial_frame_rx_ctrl_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       in_ready;

    modport master (output out_data, output out_valid, output out_last, input in_ready);
    modport slave  (input out_data, input out_valid, input out_last, output in_ready);
endinterface

// File: rtl/serial_frame_rx_ctrl_frame_buf.sv
// rtl/serial_frame_rx_ctrl_frame_buf.sv - payload buffer, synchronous write and registered read
module frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);
    logic [7:0] mem [DEPTH];

    // Payload bytes land here as they arrive; storage needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register only moves on request so the presented byte holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/serial_frame_rx_ctrl.sv
// rtl/serial_frame_rx_ctrl.sv - parses SYNC/LEN/payload/CHK frames and streams verified payloads
module serial_frame_rx_ctrl
    import serial_frame_pkg::*;
#(
    parameter int         MAIN_CLK_HZ    = 50_000_000,
    parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 100_000,
    parameter int         CNT_BITS       = 8
) (
    input  logic                   in_clk,
    input  logic                   in_rst_n,
    input  logic                   in_enable,
    output logic                   out_rx_enable,
    input  logic                   in_rx_word_finished,
    input  logic [7:0]             in_rx_parallel,
    serial_frame_rx_ctrl_if.master stream,
    output logic                   out_frame_ok,
    output logic [CNT_BITS-1:0]    out_err_chk,
    output logic [CNT_BITS-1:0]    out_err_len,
    output logic [CNT_BITS-1:0]    out_err_timeout,
    output logic [CNT_BITS-1:0]    out_err_overrun
);
    localparam int PTR_W = $clog2(MAX_LEN) + 1;
    localparam int AW    = $clog2(MAX_LEN);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    // Reject parameter sets the buffer and clocking cannot support.
    if (MAX_LEN < 2 || MAIN_CLK_HZ <= 0) begin : g_param_check
        $error("serial_frame_rx_ctrl: unsupported parameters");
    end

    t_frame_state       state, state_nxt;
    logic               fin_q, evt;
    logic [7:0]         sum, chk_sum;
    logic [PTR_W-1:0]   len, len_m1, wr_ptr, rd_ptr, rd_ptr_inc;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               valid_q, last_q;
    logic               timed, tmo_hit, xfer;
    logic               inc_chk, inc_len, inc_tmo, inc_ovr;
    logic               len_ok, wr_en, chk_ok, rd_en, xfer_last;
    logic [AW-1:0]      rd_addr;
    logic [7:0]         rd_data;

    assign evt        = in_rx_word_finished & ~fin_q;
    assign chk_sum    = sum + in_rx_parallel;
    assign len_m1     = len - PTR_W'(1);
    assign rd_ptr_inc = rd_ptr + PTR_W'(1);
    assign timed      = (state == ST_LENGTH) || (state == ST_PAYLOAD) || (state == ST_CHECK);
    assign tmo_hit    = timed && !evt && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign xfer       = valid_q && stream.in_ready;

    assign stream.out_data  = rd_data;
    assign stream.out_valid = valid_q;
    assign stream.out_last  = last_q;

    frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
        .clk     (in_clk),
        .rst_n   (in_rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (in_rx_parallel),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // State register; reset lands in Idle.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle strobes; enable drop beats timeout, a byte event beats timeout.
    always_comb begin
        state_nxt = state;
        inc_chk   = 1'b0;
        inc_len   = 1'b0;
        inc_tmo   = 1'b0;
        inc_ovr   = 1'b0;
        len_ok    = 1'b0;
        wr_en     = 1'b0;
        chk_ok    = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = rd_ptr_inc[AW-1:0];
        xfer_last = 1'b0;
        if (!in_enable) begin
            state_nxt = ST_IDLE;
        end else if (tmo_hit) begin
            inc_tmo   = 1'b1;
            state_nxt = ST_HUNT;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_HUNT;
                ST_HUNT: begin
                    if (evt && in_rx_parallel == SYNC_BYTE) state_nxt = ST_LENGTH;
                end
                ST_LENGTH: begin
                    if (evt) begin
                        if (in_rx_parallel == 8'd0 || in_rx_parallel > 8'(MAX_LEN)) begin
                            inc_len   = 1'b1;
                            state_nxt = ST_HUNT;
                        end else begin
                            len_ok    = 1'b1;
                            state_nxt = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (evt) begin
                        wr_en = 1'b1;
                        if (wr_ptr == len_m1) state_nxt = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (evt) begin
                        if (chk_sum == 8'd0) begin
                            chk_ok    = 1'b1;
                            rd_en     = 1'b1;
                            rd_addr   = '0;
                            state_nxt = ST_DRAIN;
                        end else begin
                            inc_chk   = 1'b1;
                            state_nxt = ST_HUNT;
                        end
                    end
                end
                ST_DRAIN: begin
                    inc_ovr = evt;
                    if (xfer) begin
                        if (rd_ptr == len_m1) begin
                            xfer_last = 1'b1;
                            state_nxt = ST_HUNT;
                        end else begin
                            rd_en = 1'b1;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Edge detector, frame datapath, timeout and output stream registers.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            fin_q         <= 1'b1;
            out_rx_enable <= 1'b0;
            out_frame_ok  <= 1'b0;
            len           <= '0;
            sum           <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            tmo_cnt       <= '0;
            valid_q       <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            fin_q         <= in_rx_word_finished;
            out_rx_enable <= in_enable;
            out_frame_ok  <= chk_ok;
            if (!timed || evt || tmo_hit || !in_enable) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (len_ok) begin
                len    <= in_rx_parallel[PTR_W-1:0];
                sum    <= in_rx_parallel;
                wr_ptr <= '0;
            end
            if (wr_en) begin
                sum    <= chk_sum;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (chk_ok) begin
                rd_ptr  <= '0;
                valid_q <= 1'b1;
                last_q  <= (len == PTR_W'(1));
            end else if (xfer) begin
                if (xfer_last) begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end else begin
                    rd_ptr <= rd_ptr_inc;
                    last_q <= (rd_ptr_inc == len_m1);
                end
            end
            if (!in_enable) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    // Saturating error counters, cleared only by reset.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_err_chk     <= '0;
            out_err_len     <= '0;
            out_err_timeout <= '0;
            out_err_overrun <= '0;
        end else begin
            if (inc_chk && out_err_chk != '1)     out_err_chk     <= out_err_chk + 1'b1;
            if (inc_len && out_err_len != '1)     out_err_len     <= out_err_len + 1'b1;
            if (inc_tmo && out_err_timeout != '1) out_err_timeout <= out_err_timeout + 1'b1;
            if (inc_ovr && out_err_overrun != '1) out_err_overrun <= out_err_overrun + 1'b1;
        end
    end
endmodule

// File: tb/tb_serial_frame_rx_ctrl.sv
// tb/tb_serial_frame_rx_ctrl.sv - self-checking bench for serial_frame_rx_ctrl
module tb_serial_frame_rx_ctrl;
    localparam int TMO = 200;
    localparam int NV  = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       rx_fin = 1'b0;
    logic [7:0] rx_par = 8'h00;
    logic       rx_en, frame_ok;
    logic [7:0] err_chk, err_len, err_tmo, err_ovr;

    serial_frame_rx_ctrl_if sif();

    serial_frame_rx_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .in_clk              (clk),
        .in_rst_n            (rst_n),
        .in_enable           (enable),
        .out_rx_enable       (rx_en),
        .in_rx_word_finished (rx_fin),
        .in_rx_parallel      (rx_par),
        .stream              (sif),
        .out_frame_ok        (frame_ok),
        .out_err_chk         (err_chk),
        .out_err_len         (err_len),
        .out_err_timeout     (err_tmo),
        .out_err_overrun     (err_ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [159:0] seq;
        int           n;
        logic [127:0] exp;
        int           en;
        int           ok;
        int           chk;
        int           len;
    } vec_t;

    vec_t       tbl [NV];
    logic [8:0] exp_q [$];
    logic [8:0] sb_front;
    int         checks = 0;
    int         failures = 0;
    int         ok_cnt = 0;
    int         exp_ok = 0;
    int         bad_hold;
    logic [159:0] s;
    logic [127:0] e;
    logic [7:0]   b;

    // Scoreboard: every transfer pops one expected {byte,last}.
    always @(negedge clk) begin
        if (frame_ok) ok_cnt++;
        if (sif.out_valid && sif.in_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL stream_unexpected actual=%02h last=%0b required=no byte", sif.out_data, sif.out_last);
            end else begin
                sb_front = exp_q.pop_front();
                if ({sif.out_data, sif.out_last} !== sb_front) begin
                    failures++;
                    $display("FAIL stream_byte actual=%02h/%0b required=%02h/%0b",
                             sif.out_data, sif.out_last, sb_front[8:1], sb_front[0]);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        @(posedge clk); #1;
        rx_par = v;
        rx_fin = 1'b1;
        repeat (3) @(posedge clk);
        #1 rx_fin = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic l);
        exp_q.push_back({d, l});
    endtask

    task automatic wait_drain(input string nm);
        int k = 0;
        @(negedge clk);
        while (exp_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain actual=%0d bytes pending required=0", nm, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int k = 0;
        @(negedge clk);
        while (!sif.out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_valid"}, {31'd0, sif.out_valid}, 32'd1);
    endtask

    task automatic vset(input int i, input int n, input logic [159:0] sq, input int en,
                        input logic [127:0] ex, input int ok, input int ck, input int ln);
        tbl[i].seq = sq;
        tbl[i].n   = n;
        tbl[i].exp = ex;
        tbl[i].en  = en;
        tbl[i].ok  = ok;
        tbl[i].chk = ck;
        tbl[i].len = ln;
    endtask

    task automatic send_seq(input logic [159:0] sq, input int n);
        for (int k = 0; k < n; k++) begin
            send_byte(sq[8*(n-1-k) +: 8]);
        end
    endtask

    initial begin
        // Vectors: byte sequence right-aligned, expected payload, cumulative frame_ok/err_chk/err_len.
        vset(0, 6, 160'hA50311223397,  3, 128'h112233, 1, 0, 0);
        vset(1, 6, 160'hA50311223398,  0, 128'h0,      1, 1, 0);
        vset(2, 2, 160'hA500,          0, 128'h0,      1, 1, 1);
        vset(3, 2, 160'hA511,          0, 128'h0,      1, 1, 2);
        vset(4, 7, 160'h00FF5AA5017F80, 1, 128'h7F,    2, 1, 2);
        vset(5, 5, 160'hA5020102FB,    2, 128'h0102,   3, 1, 2);
        s = '0;
        e = '0;
        s = {s[151:0], 8'hA5};
        s = {s[151:0], 8'h10};
        for (int k = 1; k <= 16; k++) begin
            s = {s[151:0], 8'(k)};
            e = {e[119:0], 8'(k)};
        end
        s = {s[151:0], 8'h68};
        vset(6, 19, s, 16, e, 4, 1, 2);

        sif.in_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_outputs", {20'd0, sif.out_data, sif.out_valid, sif.out_last, frame_ok, rx_en}, 32'd0);
        check("rst_counters", {err_chk, err_len, err_tmo, err_ovr}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        check("rx_enable_on", {31'd0, rx_en}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < tbl[i].en; k++) begin
                b = tbl[i].exp[8*(tbl[i].en-1-k) +: 8];
                push_exp(b, k == tbl[i].en - 1);
            end
            send_seq(tbl[i].seq, tbl[i].n);
            wait_drain($sformatf("vec%0d", i));
            check($sformatf("vec%0d_frame_ok", i), ok_cnt, tbl[i].ok);
            check($sformatf("vec%0d_err_chk", i), {24'd0, err_chk}, tbl[i].chk);
            check($sformatf("vec%0d_err_len", i), {24'd0, err_len}, tbl[i].len);
        end
        exp_ok = 4;

        // Timeout fires after a long gap, not after a gap just under the limit.
        send_seq(160'hA50211, 3);
        repeat (TMO + 20) @(posedge clk);
        #1;
        check("timeout_fired", {24'd0, err_tmo}, 32'd1);
        push_exp(8'h11, 1'b0);
        push_exp(8'h22, 1'b1);
        send_seq(160'hA50211, 3);
        repeat (TMO - 20) @(posedge clk);
        send_seq(160'h22CB, 2);
        wait_drain("near_timeout");
        check("timeout_not_fired", {24'd0, err_tmo}, 32'd1);
        exp_ok++;
        push_exp(8'h7F, 1'b1);
        send_seq(160'hA5017F80, 4);
        wait_drain("after_timeout");
        exp_ok++;
        check("timeout_frame_ok", ok_cnt, exp_ok);

        // Backpressure with two overrun events while the first byte is held.
        sif.in_ready = 1'b0;
        push_exp(8'h11, 1'b0);
        push_exp(8'h22, 1'b0);
        push_exp(8'h33, 1'b1);
        send_seq(160'hA50311223397, 6);
        wait_valid("bp");
        bad_hold = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ({sif.out_data, sif.out_valid, sif.out_last} !== {8'h11, 2'b10}) bad_hold++;
        end
        send_byte(8'h55);
        send_byte(8'h66);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ({sif.out_data, sif.out_valid, sif.out_last} !== {8'h11, 2'b10}) bad_hold++;
        end
        check("bp_hold_unstable_cycles", bad_hold, 0);
        check("overrun_count", {24'd0, err_ovr}, 32'd2);
        @(posedge clk); #1;
        sif.in_ready = 1'b1;
        wait_drain("bp");
        exp_ok++;
        check("bp_frame_ok", ok_cnt, exp_ok);

        // Reset mid-payload: everything clears and the partial frame never appears.
        send_seq(160'hA5040102, 4);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_outputs", {20'd0, sif.out_data, sif.out_valid, sif.out_last, frame_ok, rx_en}, 32'd0);
        check("midrst_counters", {err_chk, err_len, err_tmo, err_ovr}, 32'd0);
        rst_n = 1'b1;
        send_seq(160'h03F6, 2);
        wait_drain("midrst");
        check("midrst_no_frame", ok_cnt, exp_ok);

        // Enable drop during Drain: stream stops on the next cycle and never resumes.
        sif.in_ready = 1'b0;
        send_seq(160'hA50311223397, 6);
        wait_valid("endrop");
        exp_ok++;
        @(posedge clk); #1;
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("endrop_valid", {30'd0, sif.out_valid, sif.out_last}, 32'd0);
        check("endrop_rx_enable", {31'd0, rx_en}, 32'd0);
        sif.in_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1 enable = 1'b1;
        repeat (2) @(posedge clk);
        push_exp(8'h7F, 1'b1);
        send_seq(160'hA5017F80, 4);
        wait_drain("endrop_recover");
        exp_ok++;
        check("endrop_frame_ok", ok_cnt, exp_ok);
        check("final_counters", {err_chk, err_len, err_tmo, err_ovr}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
